ili9341_spi_tx: RTL and testbench
=================================

Name: ili9341_spi_tx

Overview:
- 4-wire SPI serializer for the ILI9341 panel. Downstream of the command/pixel sequencer.
- Accepts one 10-bit command word per handshake: bit9 = KEEP_CS, bit8 = DCX (0 command, 1 data), bits7:0 = payload.
- Drives CSX, DCX, SCLK and MOSI in SPI mode 0, MSB first.
- Implements the shift_en/load/send/done signalling between the top-level sequencer and the physical interface.

Parameters:
- CLK_DIV, 2, system clocks per SCLK half-period; legal range 1..255.
- CS_SETUP, 1, cycles CSX is low before the first SCLK phase of a frame; legal range 1..255.
- CS_HOLD, 1, cycles CSX stays low after the last SCLK fall; legal range 1..255.
- CS_GAP, 2, minimum cycles CSX stays high between frames; legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- word_i  in  10  {KEEP_CS, DCX, data[7:0]}.
- load_i  in  1  word_i valid. Accepted only when ready_o=1.
- flush_i  in  1  release CSX when idle and CSX is held low.
- ready_o  out  1  block can accept a word this cycle.
- done_o  out  1  one-cycle pulse when a word has been fully shifted out.
- spi_csx_o  out  1  chip select, active low.
- spi_dcx_o  out  1  data/command select.
- spi_sclk_o  out  1  serial clock; idles low.
- spi_mosi_o  out  1  serial data.

Behaviour:
- Clock and reset: single clock domain on clk; reset is asynchronous and active-low on rst_n.
- Reset values: spi_csx_o=1, spi_sclk_o=0, spi_mosi_o=0, spi_dcx_o=0, done_o=0, ready_o=1. The FSM resets to IDLE.
- Reset asserted mid-frame: outputs go to their reset values immediately; the word is discarded and no done_o is issued.
- All SPI outputs are registered. ready_o is high exactly when the FSM is in IDLE.
- FSM states: IDLE, SETUP, BIT_LO, BIT_HI, HOLD, GAP.
- IDLE, load_i=1: word is latched at the clock edge (accepting edge E0).
  - If CSX is high: go to SETUP. CSX=0, DCX=word[8], MOSI=word[7].
  - If CSX is already low (previous word had KEEP_CS=1): go directly to BIT_LO for bit 7. DCX and MOSI update at the same edge.
- SETUP: lasts CS_SETUP cycles, then BIT_LO for bit 7.
- BIT_LO: lasts CLK_DIV cycles, SCLK=0, MOSI holds the current bit. Then go to BIT_HI.
- BIT_HI: lasts CLK_DIV cycles, SCLK=1; the panel samples on the rising edge.
  - Then SCLK=0. If bits remain: MOSI takes the next bit and the FSM returns to BIT_LO.
  - DCX is held constant for the entire word.
- After bit 0's BIT_HI: done_o=1 for exactly one cycle, concurrent with SCLK returning low.
  - KEEP_CS=1: FSM enters IDLE in the done cycle with CSX kept low. ready_o=1 in that cycle, so a back-to-back word may be accepted at the next edge.
  - KEEP_CS=0: FSM enters HOLD.
- HOLD: lasts CS_HOLD cycles with CSX low, then CSX=1 and the FSM enters GAP.
- GAP: lasts CS_GAP cycles, then IDLE. MOSI and DCX retain their last values.
- Frame timing: from E0 with CSX high, done_o is high in the cycle following edge E(CS_SETUP+16*CLK_DIV). Keep-CS continuation omits the CS_SETUP term.
- flush_i in IDLE with CSX low: enter HOLD (CS_HOLD, then GAP, then IDLE); no done_o.
  - flush_i with CSX high, or outside IDLE: ignored.
  - load_i and flush_i in the same IDLE cycle: load_i wins and flush_i is dropped.
- load_i while ready_o=0: ignored. word_i is not sampled and there is no queuing.
- Bit counter is 3 bits and counts 7 down to 0. Phase counters are 8 bits and compare against PARAM-1. No wrap-around in counters is observable externally.

Test Plan:
- Reset release, CLK_DIV=2, CS_SETUP=1.
  - Stimulus: load word 10'h036.
  - Required response: CSX falls at E0+; DCX=0; MOSI observed at SCLK rises = 0,0,1,1,0,1,1,0; 8 SCLK rising edges, each high for 2 cycles; done_o single pulse 33 cycles after E0; CSX rises CS_HOLD cycles later; ready_o returns after CS_GAP.
- Data word 10'h155 (DCX=1, data 8'h55).
  - Required response: DCX=1 stable across all 8 bits; MOSI pattern 0,1,0,1,0,1,0,1.
- Keep-CS burst: 10'h3AA then 10'h300 then 10'h3AA, each loaded on ready_o.
  - Required response: CSX stays low throughout; 24 SCLK rises; three done_o pulses spaced 16*CLK_DIV+1 cycles apart; after the last word CSX remains low.
  - Then flush_i=1: CSX rises after CS_HOLD, with no extra done_o.
- Attempt to disturb a frame: load_i held high with a different word_i during the frame of 10'h0CB.
  - Required response: the second word is not captured until ready_o=1; the first frame's bits are unaltered.
- rst_n pulsed low during bit 4 of a frame.
  - Required response: CSX=1 and SCLK=0 immediately (asynchronous); no done_o; the next load transmits a full clean frame.
- Simultaneous load_i and flush_i in IDLE with CSX low.
  - Required response: the word is sent with no setup phase and no intermediate CSX high pulse.

Source files
------------

// File: rtl/ili9341_spi_tx.sv
// ili9341_spi_tx: 4-wire SPI mode-0 serializer for the ILI9341 panel.
// Takes one {KEEP_CS, DCX, data[7:0]} word per load/ready handshake,
// shifts it out MSB first and pulses done_o when the last bit completes.
// CSX can be held low across words (KEEP_CS) and released later by flush_i.
module ili9341_spi_tx #(
    parameter int CLK_DIV  = 2,  // system clocks per SCLK half-period
    parameter int CS_SETUP = 1,  // CSX low before first SCLK phase
    parameter int CS_HOLD  = 1,  // CSX low after last SCLK fall
    parameter int CS_GAP   = 2   // minimum CSX high between frames
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] word_i,
    input  logic       load_i,
    input  logic       flush_i,
    output logic       ready_o,
    output logic       done_o,
    output logic       spi_csx_o,
    output logic       spi_dcx_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        BIT_LO,
        BIT_HI,
        HOLD,
        GAP
    } state_t;

    // Phase counters run 0..PARAM-1.
    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);

    state_t     state;
    logic [7:0] cnt;
    logic [2:0] bit_cnt;  // index of the bit currently on MOSI
    logic [6:0] sh;       // bits still to be sent, next one in sh[6]
    logic       keep;     // KEEP_CS of the word in flight

    // ready_o is a pure decode of the state register.
    assign ready_o = (state == IDLE);

    // Frame sequencer; every SPI pin and done_o is driven from here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            bit_cnt    <= 3'd0;
            sh         <= 7'd0;
            keep       <= 1'b0;
            done_o     <= 1'b0;
            spi_csx_o  <= 1'b1;
            spi_dcx_o  <= 1'b0;
            spi_sclk_o <= 1'b0;
            spi_mosi_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // load wins over flush when both arrive together
                    if (load_i) begin
                        sh         <= word_i[6:0];
                        keep       <= word_i[9];
                        spi_dcx_o  <= word_i[8];
                        spi_mosi_o <= word_i[7];
                        bit_cnt    <= 3'd7;
                        cnt        <= 8'd0;
                        spi_csx_o  <= 1'b0;
                        // CSX already low: continuation word, no setup phase
                        state      <= spi_csx_o ? SETUP : BIT_LO;
                    end else if (flush_i && !spi_csx_o) begin
                        cnt   <= 8'd0;
                        state <= HOLD;
                    end
                end
                SETUP: begin
                    if (cnt == SETUP_M1) begin
                        cnt   <= 8'd0;
                        state <= BIT_LO;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                BIT_LO: begin
                    if (cnt == DIV_M1) begin
                        cnt        <= 8'd0;
                        spi_sclk_o <= 1'b1;
                        state      <= BIT_HI;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                BIT_HI: begin
                    if (cnt == DIV_M1) begin
                        cnt        <= 8'd0;
                        spi_sclk_o <= 1'b0;
                        if (bit_cnt != 3'd0) begin
                            bit_cnt    <= bit_cnt - 3'd1;
                            spi_mosi_o <= sh[6];
                            sh         <= {sh[5:0], 1'b0};
                            state      <= BIT_LO;
                        end else begin
                            done_o <= 1'b1;
                            state  <= keep ? IDLE : HOLD;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == HOLD_M1) begin
                        cnt       <= 8'd0;
                        spi_csx_o <= 1'b1;
                        state     <= GAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_M1) begin
                        cnt   <= 8'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ili9341_spi_tx.sv
// tb_ili9341_spi_tx: table-driven directed frames, hand-written corner
// sequences and a randomized word stream, all checked against a frame-level
// model (expected bit stream, done latency, CSX/ready windows).
module tb_ili9341_spi_tx;

    localparam int CD  = 2;
    localparam int CSS = 1;
    localparam int CH  = 2;
    localparam int CG  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] word_i = 10'd0;
    logic       load_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       ready_o, done_o, spi_csx_o, spi_dcx_o, spi_sclk_o, spi_mosi_o;

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    bit csx_low_m = 1'b0;  // model: CSX expected low while idle
    logic [9:0] cur_word = 10'd0;

    typedef struct {
        logic [9:0] w;
        logic [7:0] exp_bits;
        logic       exp_dcx;
    } vec_t;

    ili9341_spi_tx #(
        .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CH), .CS_GAP(CG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .word_i(word_i), .load_i(load_i),
        .flush_i(flush_i), .ready_o(ready_o), .done_o(done_o),
        .spi_csx_o(spi_csx_o), .spi_dcx_o(spi_dcx_o),
        .spi_sclk_o(spi_sclk_o), .spi_mosi_o(spi_mosi_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        cmp_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s word=%h: got %0d required %0d", nm, cur_word, act, exp);
        end
    endtask

    // Present a word at a falling edge once ready; returns after the accepting edge.
    task automatic drive(input logic [9:0] w, input bit fl);
        int t = 0;
        while (!ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", int'(ready_o), 1);
        cur_word = w;
        word_i = w;
        load_i = 1'b1;
        flush_i = fl;
        @(posedge clk);
    endtask

    // Observe a whole frame starting with the cycle after the accepting edge.
    task automatic monitor(input logic [9:0] w, input logic [7:0] eb, input logic ed,
                           input bit hold_ld, input logic [9:0] alt);
        int L, n_end, rises, hi, dones, done_at, csx_bad, rdy_bad, dcx_bad;
        logic [7:0] cap;
        logic prev, exp_csx, exp_rdy;
        bit keep;
        keep = w[9];
        L = csx_low_m ? 16 * CD : CSS + 16 * CD;
        n_end = keep ? L : L + CH + CG;
        rises = 0; hi = 0; dones = 0; done_at = -1;
        csx_bad = 0; rdy_bad = 0; dcx_bad = 0;
        cap = 8'd0; prev = 1'b0;
        for (int n = 0; n <= n_end; n++) begin
            @(negedge clk);
            if (n == 0) begin
                flush_i = 1'b0;
                if (hold_ld) word_i = alt;
                else load_i = 1'b0;
                chk("mosi_first", int'(spi_mosi_o), int'(w[7]));
            end
            if (spi_sclk_o && !prev) begin
                cap = {cap[6:0], spi_mosi_o};
                rises++;
            end
            if (spi_sclk_o) hi++;
            prev = spi_sclk_o;
            if (spi_dcx_o !== ed) dcx_bad++;
            if (done_o) begin
                dones++;
                done_at = n;
                last_done_cyc = cyc;
            end
            exp_csx = (keep || n < L + CH) ? 1'b0 : 1'b1;
            exp_rdy = (n == n_end);
            if (spi_csx_o !== exp_csx) csx_bad++;
            if (ready_o !== exp_rdy) rdy_bad++;
        end
        chk("sclk_rises", rises, 8);
        chk("mosi_bits", int'(cap), int'(eb));
        chk("sclk_high_cycles", hi, 8 * CD);
        chk("done_count", dones, 1);
        chk("done_latency", done_at, L);
        chk("csx_window_errs", csx_bad, 0);
        chk("dcx_errs", dcx_bad, 0);
        chk("ready_errs", rdy_bad, 0);
        csx_low_m = keep;
    endtask

    // Release a held CSX through HOLD and GAP.
    task automatic flush_seq();
        int csx_bad = 0, rdy_bad = 0, dones = 0;
        flush_i = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= CH + CG; n++) begin
            @(negedge clk);
            if (n == 0) flush_i = 1'b0;
            if (spi_csx_o !== ((n < CH) ? 1'b0 : 1'b1)) csx_bad++;
            if (ready_o !== (n == CH + CG)) rdy_bad++;
            if (done_o) dones++;
        end
        chk("flush_csx_errs", csx_bad, 0);
        chk("flush_ready_errs", rdy_bad, 0);
        chk("flush_done_count", dones, 0);
        csx_low_m = 1'b0;
    endtask

    // Idle cycles: nothing should move.
    task automatic idle(input int k);
        int bad = 0;
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            if (done_o || !ready_o || spi_sclk_o || (spi_csx_o !== !csx_low_m)) bad++;
        end
        chk("idle_errs", bad, 0);
    endtask

    initial begin
        vec_t tbl[5];
        logic [9:0] w;
        int prev_done, t, r, rises, bad;
        logic prev;
        bit chained;

        tbl[0] = '{10'h036, 8'b0011_0110, 1'b0};
        tbl[1] = '{10'h155, 8'b0101_0101, 1'b1};
        tbl[2] = '{10'h3AA, 8'b1010_1010, 1'b1};
        tbl[3] = '{10'h300, 8'b0000_0000, 1'b1};
        tbl[4] = '{10'h3AA, 8'b1010_1010, 1'b1};

        // asynchronous reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_csx", int'(spi_csx_o), 1);
        chk("rst_sclk", int'(spi_sclk_o), 0);
        chk("rst_mosi", int'(spi_mosi_o), 0);
        chk("rst_dcx", int'(spi_dcx_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_ready", int'(ready_o), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // directed table, last three form a keep-CS burst
        for (int i = 0; i < 5; i++) begin
            chained = csx_low_m;
            prev_done = last_done_cyc;
            drive(tbl[i].w, 1'b0);
            monitor(tbl[i].w, tbl[i].exp_bits, tbl[i].exp_dcx, 1'b0, 10'd0);
            if (chained) chk("burst_done_spacing", last_done_cyc - prev_done, 16 * CD + 1);
        end
        idle(3);
        flush_seq();

        // flush with CSX high is ignored
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        idle(3);

        // load held high with another word during a frame
        drive(10'h0CB, 1'b0);
        monitor(10'h0CB, 8'hCB, 1'b0, 1'b1, 10'h0F0);
        cur_word = 10'h0F0;
        @(posedge clk);
        monitor(10'h0F0, 8'hF0, 1'b0, 1'b0, 10'd0);

        // reset during bit 4
        drive(10'h1C3, 1'b0);
        rises = 0; prev = 1'b0; t = 0;
        while (rises < 4 && t < 200) begin
            @(negedge clk);
            if (t == 0) load_i = 1'b0;
            if (spi_sclk_o && !prev) rises++;
            prev = spi_sclk_o;
            t++;
        end
        chk("reach_bit4", rises, 4);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_csx", int'(spi_csx_o), 1);
        chk("midrst_sclk", int'(spi_sclk_o), 0);
        chk("midrst_ready", int'(ready_o), 1);
        @(negedge clk);
        rst_n = 1'b1;
        csx_low_m = 1'b0;
        idle(4);
        drive(10'h0A5, 1'b0);
        monitor(10'h0A5, 8'hA5, 1'b0, 1'b0, 10'd0);

        // simultaneous load and flush with CSX low
        drive(10'h212, 1'b0);
        monitor(10'h212, 8'h12, 1'b0, 1'b0, 10'd0);
        drive(10'h03C, 1'b1);
        monitor(10'h03C, 8'h3C, 1'b0, 1'b0, 10'd0);

        // randomized word stream
        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 3));
            r = $urandom_range(0, 3);
            if (csx_low_m && r == 0) begin
                flush_seq();
                idle($urandom_range(0, 2));
            end
            w = 10'($urandom);
            drive(w, csx_low_m && r == 1);
            monitor(w, w[7:0], w[8], 1'b0, 10'd0);
        end
        if (csx_low_m) flush_seq();
        bad = 0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
